// File: rtl/izneuron_sweep_ctrl.sv
// Sweep sequencer for the time-multiplexed Izhikevich population datapath.
// Walks every slot with a READ/WRITE pair per step, gathers spikes, and owns the current table.
module izneuron_sweep_ctrl #(
  parameter int N_NEURON = 128,
  parameter int IDX_W    = 7,
  parameter int I_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  host_wr_req,
  input  logic [IDX_W-1:0]      host_wr_idx,
  input  logic signed [I_W-1:0] host_wr_data,
  output logic                  host_wr_ack,
  output logic [IDX_W-1:0]      dp_idx,
  output logic                  dp_write,
  output logic signed [I_W-1:0] dp_I,
  output logic                  dp_first_pass,
  input  logic                  dp_fired,
  output logic                  spk_valid,
  output logic [IDX_W-1:0]      spk_id,
  output logic [IDX_W:0]        spk_count,
  output logic                  step_done,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_NEURON - 1);
  localparam logic [IDX_W:0]   N_CNT = (IDX_W+1)'(N_NEURON);

  state_t                state;
  logic [IDX_W:0]        acc;
  logic signed [I_W-1:0] tbl [N_NEURON];

  logic load_edge, host_acc, host_in_range;
  logic [IDX_W:0] acc_nxt;
  logic [IDX_W-1:0] idx_nxt;

  // dp_I is loaded from the table on these edges, so host writes yield for one cycle
  assign load_edge     = (state == IDLE && tick) || (state == WRITE && dp_idx != LAST);
  assign host_acc      = host_wr_req && !host_wr_ack && !load_edge;
  assign host_in_range = {1'b0, host_wr_idx} < N_CNT;
  assign acc_nxt       = acc + {{IDX_W{1'b0}}, dp_fired};
  assign idx_nxt       = dp_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      dp_idx        <= '0;
      dp_write      <= 1'b0;
      dp_I          <= '0;
      dp_first_pass <= 1'b1;
      spk_valid     <= 1'b0;
      spk_id        <= '0;
      spk_count     <= '0;
      step_done     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      host_wr_ack   <= 1'b0;
      for (int i = 0; i < N_NEURON; i++) tbl[i] <= '0;
    end else begin
      host_wr_ack <= host_acc;
      if (host_acc && host_in_range) tbl[host_wr_idx] <= host_wr_data;

      spk_valid <= 1'b0;
      step_done <= 1'b0;
      dp_write  <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: if (tick) begin
          state  <= READ;
          busy   <= 1'b1;
          dp_idx <= '0;
          dp_I   <= tbl[0];
          acc    <= '0;
        end
        READ: begin
          state    <= WRITE;
          dp_write <= 1'b1;
        end
        WRITE: begin
          acc <= acc_nxt;
          if (dp_fired) begin
            spk_valid <= 1'b1;
            spk_id    <= dp_idx;
          end
          if (dp_idx != LAST) begin
            state  <= READ;
            dp_idx <= idx_nxt;
            dp_I   <= tbl[idx_nxt];
          end else begin
            state     <= DONE;
            spk_count <= acc_nxt;
            step_done <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          dp_first_pass <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
